// File: rtl/cp0_unit.sv
// Coprocessor-0 register file (SR, Cause, EPC, PRId) and exception/interrupt arbiter.
// Optional BadVAddr at reg 8 when CP0_BADVADDR_EN is defined.
module cp0_unit #(
  parameter logic [31:0] PRID = 32'h0000_4D49
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        we,
  input  logic        exl_clr,
  input  logic [4:0]  addr,
  input  logic [31:0] din,
  input  logic [31:0] pc_save,
  input  logic        bd,
  input  logic [5:0]  hwint,
  input  logic        exc_req,
  input  logic [4:0]  exc_code,
  input  logic [31:0] bad_addr,
  output logic        exc_take,
  output logic [31:0] epc,
  output logic [31:0] dout
);

  localparam logic [4:0] A_BVA   = 5'd8;
  localparam logic [4:0] A_SR    = 5'd12;
  localparam logic [4:0] A_CAUSE = 5'd13;
  localparam logic [4:0] A_EPC   = 5'd14;
  localparam logic [4:0] A_PRID  = 5'd15;

  logic [5:0]  im_q, im_d;
  logic        exl_q, exl_d;
  logic        ie_q, ie_d;
  logic        bd_q, bd_d;
  logic [5:0]  ip_q, ip_d;
  logic [4:0]  code_q, code_d;
  logic [29:0] epc_q, epc_d;

  logic        int_req;
  logic        sr_wr;
  logic        epc_wr;
  logic [31:0] sr_word;
  logic [31:0] cause_word;

  assign int_req  = (|(hwint & im_q)) & ie_q & ~exl_q;
  assign exc_take = int_req | (exc_req & ~exl_q);

  assign sr_wr  = we & (addr == A_SR);
  assign epc_wr = we & (addr == A_EPC);

  always_comb begin
    im_d   = im_q;
    exl_d  = exl_q;
    ie_d   = ie_q;
    bd_d   = bd_q;
    code_d = code_q;
    epc_d  = epc_q;
    ip_d   = hwint;
    if (exc_take) begin
      exl_d  = 1'b1;
      epc_d  = pc_save[31:2];
      bd_d   = bd;
      code_d = int_req ? 5'd0 : exc_code;
    end else begin
      if (sr_wr) begin
        im_d  = din[15:10];
        exl_d = din[1];
        ie_d  = din[0];
      end
      if (epc_wr) begin
        epc_d = din[31:2];
      end
      // eret beats an mtc0 to SR on EXL only
      if (exl_clr) begin
        exl_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      im_q   <= '0;
      exl_q  <= 1'b0;
      ie_q   <= 1'b0;
      bd_q   <= 1'b0;
      ip_q   <= '0;
      code_q <= '0;
      epc_q  <= '0;
    end else begin
      im_q   <= im_d;
      exl_q  <= exl_d;
      ie_q   <= ie_d;
      bd_q   <= bd_d;
      ip_q   <= ip_d;
      code_q <= code_d;
      epc_q  <= epc_d;
    end
  end

  assign sr_word    = {16'b0, im_q, 8'b0, exl_q, ie_q};
  assign cause_word = {bd_q, 15'b0, ip_q, 3'b0, code_q, 2'b0};
  assign epc        = {epc_q, 2'b00};

`ifdef CP0_BADVADDR_EN
  logic [31:0] bva_q, bva_d;
  logic        bva_ld;
  logic        unused_pc_lo;

  assign bva_ld = exc_take & ~int_req
                & ((exc_code == 5'd4) | (exc_code == 5'd5));

  always_comb begin
    bva_d = bva_q;
    if (bva_ld) begin
      bva_d = bad_addr;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      bva_q <= '0;
    end else begin
      bva_q <= bva_d;
    end
  end

  assign unused_pc_lo = ^pc_save[1:0];
`else
  logic [31:0] bva_q;
  logic        unused_pc_lo;

  assign bva_q        = '0;
  assign unused_pc_lo = ^{pc_save[1:0], bad_addr};
`endif

  always_comb begin
    dout = '0;
    unique case (addr)
      A_BVA:   dout = bva_q;
      A_SR:    dout = sr_word;
      A_CAUSE: dout = cause_word;
      A_EPC:   dout = epc;
      A_PRID:  dout = PRID;
      default: dout = '0;
    endcase
  end

endmodule

// File: tb/tb_cp0_unit.sv
// Self-checking bench for cp0_unit: word-level reference model plus
// directed literal checks and a randomized phase.
module tb_cp0_unit;

  localparam logic [31:0] PRID = 32'h0000_4D49;

  logic        clk = 1'b0;
  logic        reset;
  logic        we;
  logic        exl_clr;
  logic [4:0]  addr;
  logic [31:0] din;
  logic [31:0] pc_save;
  logic        bd;
  logic [5:0]  hwint;
  logic        exc_req;
  logic [4:0]  exc_code;
  logic [31:0] bad_addr;
  logic        exc_take;
  logic [31:0] epc;
  logic [31:0] dout;

  int vectors = 0;
  int errors  = 0;

  cp0_unit #(.PRID(PRID)) dut (
    .clk(clk), .reset(reset), .we(we), .exl_clr(exl_clr),
    .addr(addr), .din(din), .pc_save(pc_save), .bd(bd),
    .hwint(hwint), .exc_req(exc_req), .exc_code(exc_code),
    .bad_addr(bad_addr), .exc_take(exc_take), .epc(epc), .dout(dout)
  );

  always #5 clk = ~clk;

  // Reference model: architectural registers as whole 32-bit words
  logic [31:0] m_sr, m_cause, m_epc, m_bva;
  bit          m_valid = 0;

  function automatic bit m_int();
    return ((hwint & m_sr[15:10]) != 6'd0) && m_sr[0] && !m_sr[1];
  endfunction

  function automatic bit m_take();
    return m_int() || (exc_req && !m_sr[1]);
  endfunction

  function automatic logic [31:0] m_read(input logic [4:0] a);
    case (a)
`ifdef CP0_BADVADDR_EN
      5'd8:  return m_bva;
`endif
      5'd12: return m_sr;
      5'd13: return m_cause;
      5'd14: return m_epc;
      5'd15: return PRID;
      default: return 32'd0;
    endcase
  endfunction

  always @(posedge clk) begin
    if (reset) begin
      m_sr = 0; m_cause = 0; m_epc = 0; m_bva = 0;
      m_valid = 1;
    end else if (m_valid) begin
      bit t, i;
      t = m_take();
      i = m_int();
      m_cause[15:10] = hwint;
      if (t) begin
        m_sr[1] = 1'b1;
        m_epc = pc_save & 32'hFFFF_FFFC;
        m_cause[31] = bd;
        m_cause[6:2] = i ? 5'd0 : exc_code;
        if (!i && (exc_code == 5'd4 || exc_code == 5'd5))
          m_bva = bad_addr;
      end else begin
        if (we && addr == 5'd12) m_sr = din & 32'h0000_FC03;
        if (we && addr == 5'd14) m_epc = din & 32'hFFFF_FFFC;
        if (exl_clr) m_sr[1] = 1'b0;
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Every-cycle comparison against the model, away from the active edge
  always @(negedge clk) begin
    if (m_valid && !reset) begin
      check("exc_take", {31'd0, exc_take}, {31'd0, m_take()});
      check("epc", epc, m_epc);
      check("dout", dout, m_read(addr));
    end
  end

  task automatic idle();
    reset = 0; we = 0; exl_clr = 0; addr = 0; din = 0;
    pc_save = 0; bd = 0; hwint = 0; exc_req = 0;
    exc_code = 0; bad_addr = 0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic lit_dout(input string n, input logic [4:0] a,
                          input logic [31:0] exp);
    addr = a;
    @(negedge clk);
    check(n, dout, exp);
    tick();
  endtask

  initial begin
    idle();
    reset = 1;
    tick(); tick();
    reset = 0;
    lit_dout("rst_prid", 5'd15, PRID);
    lit_dout("rst_sr", 5'd12, 32'd0);
    lit_dout("rst_cause", 5'd13, 32'd0);
    lit_dout("rst_epc", 5'd14, 32'd0);
    check("rst_take", {31'd0, exc_take}, 32'd0);

    // Interrupt taken
    we = 1; addr = 12; din = 32'h0000_0401;
    tick();
    we = 0; hwint = 6'b000001; pc_save = 32'h0000_3010; bd = 0;
    @(negedge clk);
    check("int_take", {31'd0, exc_take}, 32'd1);
    tick();
    lit_dout("int_sr", 5'd12, 32'h0000_0403);
    check("int_masked", {31'd0, exc_take}, 32'd0);
    lit_dout("int_cause", 5'd13, 32'h0000_0400);
    lit_dout("int_epc", 5'd14, 32'h0000_3010);

    // Internal exception with IE=0
    hwint = 0; we = 1; addr = 12; din = 32'd0;
    tick();
    we = 0; exc_req = 1; exc_code = 5'd10; bd = 1; pc_save = 32'h0000_3000;
    @(negedge clk);
    check("exc_take", {31'd0, exc_take}, 32'd1);
    tick();
    exc_req = 0; bd = 0;
    lit_dout("exc_cause", 5'd13, 32'h8000_0028);
    lit_dout("exc_epc", 5'd14, 32'h0000_3000);
    lit_dout("exc_sr", 5'd12, 32'h0000_0002);

    // Simultaneous interrupt and exception: interrupt wins
    we = 1; addr = 12; din = 32'h0000_0401;
    tick();
    we = 0; hwint = 6'b000001; exc_req = 1; exc_code = 5'd4;
    bad_addr = 32'hDEAD_BEE0; pc_save = 32'h0000_3020;
    tick();
    exc_req = 0;
    lit_dout("both_cause", 5'd13, 32'h0000_0400);
`ifdef CP0_BADVADDR_EN
    lit_dout("both_bva", 5'd8, 32'd0);
`else
    lit_dout("no_bva", 5'd8, 32'd0);
`endif

    // mtc0 EPC then eret; pending interrupt fires afterwards
    we = 1; addr = 14; din = 32'h0000_3007;
    tick();
    we = 0; exl_clr = 1;
    @(negedge clk);
    check("eret_epc", epc, 32'h0000_3004);
    check("eret_notake", {31'd0, exc_take}, 32'd0);
    tick();
    exl_clr = 0; addr = 12;
    @(negedge clk);
    check("post_eret_sr", dout, 32'h0000_0401);
    check("post_eret_take", {31'd0, exc_take}, 32'd1);
    tick();

    // we + exl_clr + exc_take on one edge: exception wins
    hwint = 0; exl_clr = 1;
    tick();
    hwint = 6'b000001; we = 1; addr = 14; din = 32'h0000_5550;
    pc_save = 32'h0000_7778;
    tick();
    we = 0; exl_clr = 0; hwint = 0;
    lit_dout("prec_epc", 5'd14, 32'h0000_7778);
    lit_dout("prec_sr", 5'd12, 32'h0000_0403);

    // Reset while in an exception
    reset = 1; exc_req = 1;
    tick();
    reset = 0; exc_req = 0;
    lit_dout("rst2_sr", 5'd12, 32'd0);

    // Randomized phase
    for (int n = 0; n < 4000; n++) begin
      int r;
      reset   = ($urandom_range(0, 199) == 0);
      we      = ($urandom_range(0, 3) == 0);
      exl_clr = ($urandom_range(0, 6) == 0);
      exc_req = ($urandom_range(0, 6) == 0);
      r = $urandom_range(0, 5);
      case (r)
        0: addr = 5'd8;
        1: addr = 5'd12;
        2: addr = 5'd13;
        3: addr = 5'd14;
        4: addr = 5'd15;
        default: addr = 5'($urandom);
      endcase
      din      = $urandom;
      pc_save  = $urandom;
      bd       = 1'($urandom);
      hwint    = ($urandom_range(0, 2) == 0) ? 6'($urandom) : 6'd0;
      exc_code = ($urandom_range(0, 1) == 0) ? 5'd4 + 5'($urandom_range(0, 1))
                                             : 5'($urandom);
      bad_addr = $urandom;
      tick();
    end

    idle();
    tick();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
